// File: rtl/sparrow_pkg.sv
// sparrow_pkg
//   Shared types and constants for the sparrow front end.
//   - riscv_op_e  : 7-bit major opcodes understood by the decoder (OP_LOAD among them)
//   - TYPE_*      : bit positions of the {r,i,s,b,u,j} instruction-format flags
//   - issue_pkt_t : decoded instruction as held in the issue output register
//   - reg_onehot  : one-hot register mask that never marks x0
package sparrow_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } riscv_op_e;

    // Bit positions inside the 6-bit type vector {r,i,s,b,u,j}.
    localparam int TYPE_R = 5;
    localparam int TYPE_I = 4;
    localparam int TYPE_S = 3;
    localparam int TYPE_B = 2;
    localparam int TYPE_U = 1;
    localparam int TYPE_J = 0;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        riscv_op_e   op;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [5:0]  itype;
    } issue_pkt_t;

    // x0 is hard-wired zero, so it is never pending and never a hazard source.
    function automatic logic [31:0] reg_onehot(input logic [4:0] r);
        logic [31:0] m;
        m = 32'd0;
        if (r != 5'd0) begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sparrow_decode.sv
// sparrow_decode
//   Purely combinational RV32 instruction decoder.
//   Ports:
//     i_instr       in   32  raw instruction
//     o_pkt         out  issue_pkt_t  register fields, opcode, funct3/7, immediate, type flags
//     o_rs1_used    out  1   instruction reads rs1 (R,I,S,B)
//     o_rs2_used    out  1   instruction reads rs2 (R,S,B)
//     o_rd_written  out  1   instruction writes rd (R,I,U,J)
//   Register and funct fields are the raw bit slices regardless of format; unknown
//   opcodes produce no type flag, a zero immediate and no operand usage.
module sparrow_decode
    import sparrow_pkg::*;
(
    input  logic [31:0] i_instr,
    output issue_pkt_t  o_pkt,
    output logic        o_rs1_used,
    output logic        o_rs2_used,
    output logic        o_rd_written
);

    logic [6:0] opcode;
    logic [5:0] itype;
    logic [31:0] imm;

    assign opcode = i_instr[6:0];

    always_comb begin
        itype = 6'd0;
        imm   = 32'd0;
        case (opcode)
            OP_REG: begin
                itype[TYPE_R] = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                itype[TYPE_I] = 1'b1;
                imm = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OP_STORE: begin
                itype[TYPE_S] = 1'b1;
                imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OP_BRANCH: begin
                itype[TYPE_B] = 1'b1;
                imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                itype[TYPE_U] = 1'b1;
                imm = {i_instr[31:12], 12'd0};
            end
            OP_JAL: begin
                itype[TYPE_J] = 1'b1;
                imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
            end
            default: begin
                itype = 6'd0;
                imm   = 32'd0;
            end
        endcase
    end

    always_comb begin
        o_pkt        = '0;
        o_pkt.rs1    = i_instr[19:15];
        o_pkt.rs2    = i_instr[24:20];
        o_pkt.rd     = i_instr[11:7];
        // Unknown opcodes are carried through unchanged, hence the plain cast.
        o_pkt.op     = riscv_op_e'(opcode);
        o_pkt.funct3 = i_instr[14:12];
        o_pkt.funct7 = i_instr[31:25];
        o_pkt.imm    = imm;
        o_pkt.itype  = itype;
    end

    assign o_rs1_used   = itype[TYPE_R] | itype[TYPE_I] | itype[TYPE_S] | itype[TYPE_B];
    assign o_rs2_used   = itype[TYPE_R] | itype[TYPE_S] | itype[TYPE_B];
    assign o_rd_written = itype[TYPE_R] | itype[TYPE_I] | itype[TYPE_U] | itype[TYPE_J];

endmodule

// File: rtl/sparrow_issue_ctrl.sv
// sparrow_issue_ctrl
//   Issue stage between fetch and execute. Decodes the fetched instruction in zero
//   cycles, holds it in a one-entry output register, and stalls fetch on RAW/WAW
//   hazards against outstanding load writebacks tracked in a 32-entry scoreboard.
//   Ports:
//     i_clk, i_rst            clock, synchronous active-high reset
//     i_valid/i_instr/o_ready fetch side handshake
//     o_valid/i_ready         execute side handshake
//     o_rs1..o_type           registered decode fields of the held instruction
//     i_wb_valid/i_wb_rd      load writeback completion
//     i_flush                 drop the held instruction (branch redirect)
//     o_busy_map              scoreboard, bit n set while xn has a load in flight
//     o_stall_cnt             saturating count of cycles with i_valid & !o_ready
//   Handshakes: a transfer happens on a cycle where valid and ready are both high;
//   o_ready never looks at i_valid, and the held fields stay stable while
//   o_valid & !i_ready.
module sparrow_issue_ctrl
    import sparrow_pkg::*;
#(
    parameter int         STALL_CNT_W = 16,
    parameter logic [6:0] LOAD_OPCODE = 7'b0000011
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [31:0]            i_instr,
    output logic                   o_ready,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [4:0]             o_rs1,
    output logic [4:0]             o_rs2,
    output logic [4:0]             o_rd,
    output riscv_op_e              o_op,
    output logic [2:0]             o_funct3,
    output logic [6:0]             o_funct7,
    output logic [31:0]            o_imm,
    output logic [5:0]             o_type,
    input  logic                   i_wb_valid,
    input  logic [4:0]             i_wb_rd,
    input  logic                   i_flush,
    output logic [31:0]            o_busy_map,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    issue_pkt_t dec_pkt;
    logic       dec_rs1_used;
    logic       dec_rs2_used;
    logic       dec_rd_written;

    sparrow_decode u_decode (
        .i_instr      (i_instr),
        .o_pkt        (dec_pkt),
        .o_rs1_used   (dec_rs1_used),
        .o_rs2_used   (dec_rs2_used),
        .o_rd_written (dec_rd_written)
    );

    issue_pkt_t             held_q, held_d;
    logic                   valid_q, valid_d;
    logic [31:0]            sb_q, sb_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic [6:0]  held_op;
    logic        held_is_load;
    logic [31:0] pend;
    logic        dec_valid;
    logic        hazard;
    logic        ready;
    logic        accept;
    logic        issue;

    assign held_op      = held_q.op;
    assign held_is_load = (held_op == LOAD_OPCODE);

    // A load sitting in the output register is about to become outstanding, so it
    // already blocks dependants even though its scoreboard bit is not yet set.
    always_comb begin
        pend = sb_q;
        if (valid_q && held_is_load) begin
            pend = pend | reg_onehot(held_q.rd);
        end
        pend[0] = 1'b0;
    end

    // Hazard looks only at registered state: a writeback this cycle does not
    // release the stall until the following cycle.
    assign dec_valid = |dec_pkt.itype;
    assign hazard    = dec_valid & ((dec_rs1_used   & pend[dec_pkt.rs1]) |
                                    (dec_rs2_used   & pend[dec_pkt.rs2]) |
                                    (dec_rd_written & pend[dec_pkt.rd]));

    assign ready  = ~i_flush & ~hazard & (~valid_q | i_ready);
    assign accept = i_valid & ready;
    assign issue  = valid_q & i_ready;

    // Output register: accept implies no flush, so flush wins over a new accept.
    always_comb begin
        held_d  = held_q;
        valid_d = valid_q;
        if (accept) begin
            held_d = dec_pkt;
        end
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (issue) begin
            valid_d = 1'b0;
        end
    end

    // Scoreboard: clear first, then set, so a same-register set/clear leaves it set.
    // An issue in a flush cycle still completes and must still be tracked.
    always_comb begin
        sb_d = sb_q;
        if (i_wb_valid) begin
            sb_d = sb_d & ~reg_onehot(i_wb_rd);
        end
        if (issue && held_is_load) begin
            sb_d = sb_d | reg_onehot(held_q.rd);
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (i_valid && !ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            held_q  <= '0;
            valid_q <= 1'b0;
            sb_q    <= 32'd0;
            stall_q <= '0;
        end else begin
            held_q  <= held_d;
            valid_q <= valid_d;
            sb_q    <= sb_d;
            stall_q <= stall_d;
        end
    end

    assign o_ready     = ready;
    assign o_valid     = valid_q;
    assign o_rs1       = held_q.rs1;
    assign o_rs2       = held_q.rs2;
    assign o_rd        = held_q.rd;
    assign o_op        = held_q.op;
    assign o_funct3    = held_q.funct3;
    assign o_funct7    = held_q.funct7;
    assign o_imm       = held_q.imm;
    assign o_type      = held_q.itype;
    assign o_busy_map  = sb_q;
    assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_sparrow_issue_ctrl.sv
module tb_sparrow_issue_ctrl;
  import sparrow_pkg::*;

  // clock / reset / DUT signals
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_instr;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  riscv_op_e   o_op;
  logic [2:0]  o_funct3;
  logic [6:0]  o_funct7;
  logic [31:0] o_imm;
  logic [5:0]  o_type;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic        i_flush;
  logic [31:0] o_busy_map;
  logic [15:0] o_stall_cnt;

  always #5 i_clk = ~i_clk;

  sparrow_issue_ctrl #(.STALL_CNT_W(16), .LOAD_OPCODE(7'b0000011)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_instr(i_instr),
    .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_op(o_op),
    .o_funct3(o_funct3), .o_funct7(o_funct7), .o_imm(o_imm), .o_type(o_type),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_flush(i_flush),
    .o_busy_map(o_busy_map), .o_stall_cnt(o_stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  // reference model: held instruction, set of pending load destinations, stall count
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_busy;
  int          m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // instruction builders
  function automatic logic [31:0] mk_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h004, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] mk_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'h00, rs2, rs1, 3'b010, 5'h08, 7'b0100011};
  endfunction
  function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] mk_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  // instruction format per RISC-V base encoding: {r,i,s,b,u,j}
  function automatic logic [5:0] m_type(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011:                         return 6'b100000;
      7'b0010011, 7'b0000011, 7'b1100111: return 6'b010000;
      7'b0100011:                         return 6'b001000;
      7'b1100011:                         return 6'b000100;
      7'b0110111, 7'b0010111:             return 6'b000010;
      7'b1101111:                         return 6'b000001;
      default:                            return 6'b000000;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    logic [5:0] t;
    t = m_type(ins);
    if (t == 6'b010000) return {{20{ins[31]}}, ins[31:20]};
    if (t == 6'b001000) return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    if (t == 6'b000100) return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    if (t == 6'b000010) return {ins[31:12], 12'h000};
    if (t == 6'b000001) return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    return 32'h0;
  endfunction

  function automatic bit is_load(input logic [31:0] ins);
    return ins[6:0] == 7'b0000011;
  endfunction

  // expected o_ready for the current inputs against the model state
  function automatic bit m_ready();
    logic [31:0] pend;
    logic [5:0]  t;
    bit          reads1, reads2, writes, hz;
    pend = m_busy;
    if (m_valid && is_load(m_instr) && m_instr[11:7] != 5'd0) pend[m_instr[11:7]] = 1'b1;
    t = m_type(i_instr);
    reads1 = (t == 6'b100000) || (t == 6'b010000) || (t == 6'b001000) || (t == 6'b000100);
    reads2 = (t == 6'b100000) || (t == 6'b001000) || (t == 6'b000100);
    writes = (t == 6'b100000) || (t == 6'b010000) || (t == 6'b000010) || (t == 6'b000001);
    hz = 1'b0;
    if (reads1 && i_instr[19:15] != 5'd0 && pend[i_instr[19:15]]) hz = 1'b1;
    if (reads2 && i_instr[24:20] != 5'd0 && pend[i_instr[24:20]]) hz = 1'b1;
    if (writes && i_instr[11:7]  != 5'd0 && pend[i_instr[11:7]])  hz = 1'b1;
    return !i_flush && !hz && (!m_valid || i_ready);
  endfunction

  task automatic m_step(input bit rdy);
    bit issued;
    issued = m_valid && i_ready;
    if (i_wb_valid && i_wb_rd != 5'd0) m_busy[i_wb_rd] = 1'b0;
    if (issued && is_load(m_instr) && m_instr[11:7] != 5'd0) m_busy[m_instr[11:7]] = 1'b1;
    if (i_valid && !rdy && m_stall < 65535) m_stall++;
    if (i_flush) m_valid = 1'b0;
    else if (i_valid && rdy) begin
      m_valid = 1'b1;
      m_instr = i_instr;
    end else if (issued) m_valid = 1'b0;
  endtask

  // one clock: check o_ready before the edge, registered outputs after it
  task automatic cycle();
    bit er;
    bit rst_now;
    er = 1'b0;
    #1;
    rst_now = i_rst;
    if (!rst_now) begin
      er = m_ready();
      chk("o_ready", {31'd0, o_ready}, {31'd0, er});
    end
    @(posedge i_clk);
    if (rst_now) begin
      m_valid = 1'b0;
      m_busy  = 32'd0;
      m_stall = 0;
    end else m_step(er);
    #1;
    chk("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
    chk("o_busy_map", o_busy_map, m_busy);
    chk("o_stall_cnt", {16'd0, o_stall_cnt}, 32'(m_stall));
    if (rst_now) begin
      chk("rst_fields", {o_rs1, o_rs2, o_rd, o_op, o_funct3, o_funct7}, 32'd0);
      chk("rst_imm", o_imm, 32'd0);
      chk("rst_type", {26'd0, o_type}, 32'd0);
    end else if (m_valid) begin
      chk("o_rs1", {27'd0, o_rs1}, {27'd0, m_instr[19:15]});
      chk("o_rs2", {27'd0, o_rs2}, {27'd0, m_instr[24:20]});
      chk("o_rd", {27'd0, o_rd}, {27'd0, m_instr[11:7]});
      chk("o_op", {25'd0, o_op}, {25'd0, m_instr[6:0]});
      chk("o_funct3", {29'd0, o_funct3}, {29'd0, m_instr[14:12]});
      chk("o_funct7", {25'd0, o_funct7}, {25'd0, m_instr[31:25]});
      chk("o_imm", o_imm, m_imm(m_instr));
      chk("o_type", {26'd0, o_type}, {26'd0, m_type(m_instr)});
    end
    @(negedge i_clk);
  endtask

  logic [6:0] op_tab [10];
  int         s0;

  initial begin
    op_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
               7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
    m_valid = 1'b0; m_instr = 32'd0; m_busy = 32'd0; m_stall = 0;
    i_rst = 1'b1; i_valid = 1'b0; i_instr = 32'd0; i_ready = 1'b0;
    i_wb_valid = 1'b0; i_wb_rd = 5'd0; i_flush = 1'b0;
    @(negedge i_clk);
    cycle();
    cycle();
    i_rst = 1'b0;

    // 1: reset mid-stream with a held instruction and x5 pending
    i_ready = 1'b1; i_valid = 1'b1; i_instr = mk_lw(5'd5, 5'd2);
    cycle();
    i_instr = mk_addi(5'd9, 5'd1, 12'h010);
    cycle();
    i_ready = 1'b0; i_valid = 1'b0;
    cycle();
    chk("t1_pre_valid", {31'd0, o_valid}, 32'd1);
    chk("t1_pre_busy", o_busy_map, 32'h0000_0020);
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    chk("t1_valid", {31'd0, o_valid}, 32'd0);
    chk("t1_busy", o_busy_map, 32'd0);
    chk("t1_stall", {16'd0, o_stall_cnt}, 32'd0);

    // 2: independent ADDI stream at full rate
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_valid = 1'b1;
      i_instr = mk_addi(5'(10 + k), 5'(20 + k), 12'(k * 3 + 1));
      cycle();
      chk("t2_valid", {31'd0, o_valid}, 32'd1);
    end
    chk("t2_stall", {16'd0, o_stall_cnt}, 32'd0);
    i_valid = 1'b0;
    cycle();

    // 3: LW x5 then dependent ADD x6,x5,x1
    s0 = m_stall;
    i_valid = 1'b1; i_instr = mk_lw(5'd5, 5'd2);
    cycle();
    i_instr = mk_add(5'd6, 5'd5, 5'd1);
    cycle();
    chk("t3_busy_set", {31'd0, o_busy_map[5]}, 32'd1);
    cycle();
    cycle();
    i_wb_valid = 1'b1; i_wb_rd = 5'd5;
    cycle();
    i_wb_valid = 1'b0;
    chk("t3_busy_clr", {31'd0, o_busy_map[5]}, 32'd0);
    chk("t3_ready_after_wb", {31'd0, o_ready}, 32'd1);
    cycle();
    chk("t3_stall", {16'd0, o_stall_cnt}, 32'(s0 + 4));
    i_valid = 1'b0;
    cycle();

    // 4: LW x5 held, SW x5 blocked by the held-load term
    i_ready = 1'b0; i_valid = 1'b1; i_instr = mk_lw(5'd5, 5'd2);
    cycle();
    i_instr = mk_sw(5'd5, 5'd3);
    cycle();
    cycle();
    chk("t4_held_stall", {31'd0, o_ready}, 32'd0);
    chk("t4_busy_empty", {31'd0, o_busy_map[5]}, 32'd0);
    i_ready = 1'b1;
    cycle();
    chk("t4_busy_set", {31'd0, o_busy_map[5]}, 32'd1);
    i_wb_valid = 1'b1; i_wb_rd = 5'd5;
    cycle();
    i_wb_valid = 1'b0;
    cycle();
    i_valid = 1'b0;
    cycle();

    // 5: writeback of x7 in the same cycle LW x7 issues; then LW x0
    i_ready = 1'b0; i_valid = 1'b1; i_instr = mk_lw(5'd7, 5'd2);
    cycle();
    i_valid = 1'b0; i_ready = 1'b1; i_wb_valid = 1'b1; i_wb_rd = 5'd7;
    cycle();
    chk("t5_set_wins", {31'd0, o_busy_map[7]}, 32'd1);
    cycle();
    i_wb_valid = 1'b0;
    chk("t5_clear", o_busy_map, 32'd0);
    s0 = m_stall;
    i_valid = 1'b1; i_instr = mk_lw(5'd0, 5'd7);
    cycle();
    i_instr = mk_add(5'd3, 5'd0, 5'd0);
    cycle();
    chk("t5_x0_busy", o_busy_map, 32'd0);
    chk("t5_x0_stall", {16'd0, o_stall_cnt}, 32'(s0));
    i_valid = 1'b0;
    cycle();

    // 6: flush with a held instruction, execute stalled, fetch presenting
    i_valid = 1'b1; i_instr = mk_lw(5'd3, 5'd2);
    cycle();
    i_instr = mk_addi(5'd12, 5'd13, 12'h005);
    cycle();
    i_ready = 1'b0; i_instr = mk_addi(5'd14, 5'd15, 12'h001); i_flush = 1'b1;
    #1;
    chk("t6_ready", {31'd0, o_ready}, 32'd0);
    cycle();
    i_flush = 1'b0;
    chk("t6_valid", {31'd0, o_valid}, 32'd0);
    chk("t6_busy", {31'd0, o_busy_map[3]}, 32'd1);
    i_valid = 1'b0; i_wb_valid = 1'b1; i_wb_rd = 5'd3;
    cycle();
    i_wb_valid = 1'b0;

    // randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = op_tab[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      i_instr    = ins;
      i_valid    = ($urandom_range(0, 3) != 0);
      i_ready    = ($urandom_range(0, 3) != 0);
      i_flush    = ($urandom_range(0, 19) == 0);
      i_wb_valid = ($urandom_range(0, 2) == 0);
      i_wb_rd    = 5'($urandom_range(0, 7));
      cycle();
    end

    // stall counter saturation: hold an instruction with execute stalled
    i_flush = 1'b0; i_wb_valid = 1'b0; i_ready = 1'b1;
    i_valid = 1'b1; i_instr = mk_addi(5'd1, 5'd2, 12'h003);
    cycle();
    i_valid = 1'b0;
    cycle();
    i_valid = 1'b1; i_instr = mk_addi(5'd4, 5'd2, 12'h003);
    cycle();
    i_ready = 1'b0;
    repeat (65540) @(negedge i_clk);
    m_stall = (m_stall + 65540 > 65535) ? 65535 : m_stall + 65540;
    chk("sat_cnt", {16'd0, o_stall_cnt}, 32'h0000_FFFF);
    cycle();
    chk("sat_hold", {16'd0, o_stall_cnt}, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
